// File: rtl/jump_scheduler.sv
// jump_scheduler
//
// Sequences the player's jumps against the scrolling block field. Debounced
// button levels are turned into registered rising-edge strobes. Accepted
// strobes become single-cycle jump_left/jump_right pulses to the blocks
// datapath. A new jump is not issued until the current layer-shift
// animation (SHIFT_MS one_ms_tick pulses) has finished. The block also
// tracks the character column, keeps a saturating score, advances an LFSR
// that picks the next layer pattern, and latches jump_fail into a terminal
// FAIL state.
//
// Build option:
//   JUMP_QUEUE_EN  when defined, a one-entry pending slot stores the first
//                  edge that arrives during a shift. That jump is issued
//                  directly when the shift completes. When undefined, edges
//                  during a shift are dropped.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   one_ms_tick   one-cycle pulse per millisecond
//   game_active   high while a game is in progress (from menu logic)
//   btn_left      debounced left button level
//   btn_right     debounced right button level
//   jump_fail     registered fail flag from the blocks datapath
//   jump_left     one-cycle jump-left pulse
//   jump_right    one-cycle jump-right pulse
//   layer_select  pattern-select bit for the block generator (LFSR bit 0)
//   module_en     layer-map injection enable (RUN and SHIFT)
//   busy          high while a shift animation runs
//   game_over     high in FAIL
//   column        current character column, 0..COL_MAX
//   score         successful jumps, saturating at 1023
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no game; button edges ignored, waits for rising game_active
// RUN   | game running, no animation; accepts in-range jump requests
// SHIFT | layer-shift animation running; counts one_ms_tick pulses
// FAIL  | jump_fail seen; outputs frozen until game_active falls

module jump_scheduler #(
    parameter int SHIFT_MS  = 200,
    parameter int COL_MAX   = 6,
    parameter int COL_START = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_ms_tick,
    input  logic       game_active,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       jump_fail,
    output logic       jump_left,
    output logic       jump_right,
    output logic       layer_select,
    output logic       module_en,
    output logic       busy,
    output logic       game_over,
    output logic [2:0] column,
    output logic [9:0] score
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SHIFT,
        S_FAIL
    } state_t;

    localparam int CNT_W = $clog2(SHIFT_MS + 1);

    state_t           state_q, state_d;
    logic             btn_left_q, btn_right_q;
    logic             edge_left_q, edge_left_d;
    logic             edge_right_q, edge_right_d;
    logic             game_active_q;
    logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [2:0]       column_q, column_d;
    logic [9:0]       score_q, score_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             layer_q, layer_d;
    logic             jump_left_q, jump_left_d;
    logic             jump_right_q, jump_right_d;
`ifdef JUMP_QUEUE_EN
    logic             pend_valid_q, pend_valid_d;
    logic             pend_right_q, pend_right_d;
`endif

    logic ga_rise, ga_fall, edge_any, shift_done;
    logic issue_req, issue_right, issue_ok;
    logic rise_left, rise_right;

    always_comb begin
        rise_left    = btn_left & ~btn_left_q;
        rise_right   = btn_right & ~btn_right_q;
        // Simultaneous left and right edges cancel each other.
        edge_left_d  = rise_left & ~rise_right;
        edge_right_d = rise_right & ~rise_left;

        ga_rise  = game_active & ~game_active_q;
        ga_fall  = ~game_active & game_active_q;
        edge_any = edge_left_q | edge_right_q;

        state_d      = state_q;
        ms_cnt_d     = ms_cnt_q;
        column_d     = column_q;
        score_d      = score_q;
        lfsr_d       = lfsr_q;
        layer_d      = layer_q;
        jump_left_d  = 1'b0;
        jump_right_d = 1'b0;
        issue_req    = 1'b0;
        issue_right  = 1'b0;
        issue_ok     = 1'b0;
        shift_done   = 1'b0;
`ifdef JUMP_QUEUE_EN
        pend_valid_d = pend_valid_q;
        pend_right_d = pend_right_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (ga_rise) begin
                    state_d  = S_RUN;
                    column_d = 3'(COL_START);
                    score_d  = '0;
                end
            end
            S_RUN: begin
                if (jump_fail) begin
                    state_d = S_FAIL;
                end else if (ga_fall) begin
                    state_d = S_IDLE;
                end else if (edge_any) begin
                    issue_req   = 1'b1;
                    issue_right = edge_right_q;
                end
            end
            S_SHIFT: begin
                if (jump_fail) begin
                    state_d = S_FAIL;
`ifdef JUMP_QUEUE_EN
                    pend_valid_d = 1'b0;
`endif
                end else if (ga_fall) begin
                    state_d = S_IDLE;
`ifdef JUMP_QUEUE_EN
                    pend_valid_d = 1'b0;
`endif
                end else begin
                    if (one_ms_tick) begin
                        ms_cnt_d = ms_cnt_q + CNT_W'(1);
                    end
                    shift_done = one_ms_tick && (ms_cnt_d == CNT_W'(SHIFT_MS));
                    if (shift_done) begin
                        if (score_q != 10'd1023) begin
                            score_d = score_q + 10'd1;
                        end
                        state_d = S_RUN;
`ifdef JUMP_QUEUE_EN
                        // An edge landing exactly on the final tick is treated
                        // as if it had been stored and is issued straight away.
                        if (pend_valid_q) begin
                            issue_req   = 1'b1;
                            issue_right = pend_right_q;
                        end else if (edge_any) begin
                            issue_req   = 1'b1;
                            issue_right = edge_right_q;
                        end
                        pend_valid_d = 1'b0;
`endif
                    end
`ifdef JUMP_QUEUE_EN
                    else if (edge_any && !pend_valid_q) begin
                        pend_valid_d = 1'b1;
                        pend_right_d = edge_right_q;
                    end
`endif
                end
            end
            S_FAIL: begin
                if (ga_fall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shared issue path for RUN requests and the queued jump at the end
        // of a shift; range is always checked against the current column.
        if (issue_req) begin
            issue_ok = issue_right ? (column_q < 3'(COL_MAX)) : (column_q != 3'd0);
            if (issue_ok) begin
                jump_right_d = issue_right;
                jump_left_d  = ~issue_right;
                column_d     = issue_right ? column_q + 3'd1 : column_q - 3'd1;
                lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                layer_d      = lfsr_d[0];
                ms_cnt_d     = '0;
                state_d      = S_SHIFT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            btn_left_q    <= 1'b0;
            btn_right_q   <= 1'b0;
            edge_left_q   <= 1'b0;
            edge_right_q  <= 1'b0;
            game_active_q <= 1'b0;
            ms_cnt_q      <= '0;
            column_q      <= 3'(COL_START);
            score_q       <= '0;
            lfsr_q        <= 8'hA5;
            layer_q       <= 1'b0;
            jump_left_q   <= 1'b0;
            jump_right_q  <= 1'b0;
`ifdef JUMP_QUEUE_EN
            pend_valid_q  <= 1'b0;
            pend_right_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            btn_left_q    <= btn_left;
            btn_right_q   <= btn_right;
            edge_left_q   <= edge_left_d;
            edge_right_q  <= edge_right_d;
            game_active_q <= game_active;
            ms_cnt_q      <= ms_cnt_d;
            column_q      <= column_d;
            score_q       <= score_d;
            lfsr_q        <= lfsr_d;
            layer_q       <= layer_d;
            jump_left_q   <= jump_left_d;
            jump_right_q  <= jump_right_d;
`ifdef JUMP_QUEUE_EN
            pend_valid_q  <= pend_valid_d;
            pend_right_q  <= pend_right_d;
`endif
        end
    end

    assign jump_left    = jump_left_q;
    assign jump_right   = jump_right_q;
    assign layer_select = layer_q;
    assign module_en    = (state_q == S_RUN) || (state_q == S_SHIFT);
    assign busy         = (state_q == S_SHIFT);
    assign game_over    = (state_q == S_FAIL);
    assign column       = column_q;
    assign score        = score_q;

endmodule

// File: tb/tb_jump_scheduler.sv
// Scoreboard bench for jump_scheduler. The driver predicts each jump pulse
// (direction, cycle, column, layer bit) from a game-level model and queues
// it; a negedge monitor pops and compares whenever a pulse appears.
module tb_jump_scheduler;

    localparam int SHIFT_MS  = 4;
    localparam int COL_MAX   = 6;
    localparam int COL_START = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       one_ms_tick = 1'b0;
    logic       game_active = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       jump_fail = 1'b0;
    logic       jump_left, jump_right, layer_select, module_en, busy, game_over;
    logic [2:0] column;
    logic [9:0] score;

    jump_scheduler #(
        .SHIFT_MS (SHIFT_MS),
        .COL_MAX  (COL_MAX),
        .COL_START(COL_START)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .one_ms_tick (one_ms_tick),
        .game_active (game_active),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .jump_fail   (jump_fail),
        .jump_left   (jump_left),
        .jump_right  (jump_right),
        .layer_select(layer_select),
        .module_en   (module_en),
        .busy        (busy),
        .game_over   (game_over),
        .column      (column),
        .score       (score)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit right;
        int at;
        int col;
        bit ls;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Game-level reference model
    int         m_col;
    int         m_score;
    logic [7:0] m_lfsr;

`ifdef JUMP_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic bit in_range(input bit right, input int col);
        return right ? (col < COL_MAX) : (col > 0);
    endfunction

    // Model of an issued jump: column moves, pattern advances, pulse expected.
    task automatic model_issue(input bit right, input int at);
        exp_t e;
        m_col  = right ? m_col + 1 : m_col - 1;
        m_lfsr = lfsr_step(m_lfsr);
        e.right = right;
        e.at    = at;
        e.col   = m_col;
        e.ls    = m_lfsr[0];
        sb.push_back(e);
    endtask

    function automatic int sat_inc(input int s);
        return (s < 1023) ? s + 1 : 1023;
    endfunction

    always @(negedge clk) begin
        if (!rst && (jump_left || jump_right)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {jump_left, jump_right}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_dir", {jump_left, jump_right}, e.right ? 1 : 2);
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_column", column, e.col);
                chk("pulse_layer", layer_select, e.ls);
                chk("pulse_busy", busy, 1);
            end
        end
    end

    // All driver tasks are entered and left right after a negedge.
    task automatic press_raw(input bit l, input bit r);
        btn_left  = l;
        btn_right = r;
        @(negedge clk);
        @(negedge clk);
        btn_left  = 1'b0;
        btn_right = 1'b0;
    endtask

    task automatic start_jump(input bit right, output bit ok);
        int p;
        ok = in_range(right, m_col);
        p  = cyc;
        if (ok) model_issue(right, p + 2);
        press_raw(!right, right);
        chk("start_busy", busy, ok);
        chk("start_column", column, m_col);
    endtask

    task automatic run_ticks(input int n, input int max_gap, input bit busy_exp,
                             input bit push_q, input bit qright, output int last);
        last = cyc;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            if (i == n - 1) begin
                chk("busy_before_last_tick", busy, busy_exp);
                if (push_q) model_issue(qright, cyc + 1);
            end
            one_ms_tick = 1'b1;
            last = cyc;
            @(negedge clk);
            one_ms_tick = 1'b0;
        end
    endtask

    task automatic do_jump(input bit right, input bit queue, input bit qright, input int max_gap);
        bit ok, qok;
        int last;
        start_jump(right, ok);
        if (!ok) begin
            @(negedge clk);
            return;
        end
        if (queue) begin
            @(negedge clk);
            btn_left  = !qright;
            btn_right = qright;
            @(negedge clk);
            @(negedge clk);
            btn_left  = 1'b0;
            btn_right = 1'b0;
        end
        @(negedge clk);
        qok = queue && QUEUE_EN && in_range(qright, m_col);
        run_ticks(SHIFT_MS, max_gap, 1'b1, qok, qright, last);
        m_score = sat_inc(m_score);
        chk("score_after_shift", score, m_score);
        chk("busy_after_shift", busy, qok);
        if (qok) begin
            run_ticks(SHIFT_MS, max_gap, 1'b1, 1'b0, 1'b0, last);
            m_score = sat_inc(m_score);
            chk("score_after_queued", score, m_score);
            chk("busy_after_queued", busy, 0);
        end
    endtask

    task automatic model_reset();
        m_col   = COL_START;
        m_score = 0;
        m_lfsr  = 8'hA5;
        sb.delete();
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int last;
        model_reset();

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_column", column, COL_START);
        chk("rst_score", score, 0);
        chk("rst_layer", layer_select, 0);
        chk("rst_module_en", module_en, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_jumps", {jump_left, jump_right}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Edges in IDLE are ignored
        press_raw(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("idle_column", column, COL_START);
        chk("idle_module_en", module_en, 0);

        // Start game
        game_active = 1'b1;
        repeat (2) @(negedge clk);
        chk("start_module_en", module_en, 1);
        chk("start_col", column, COL_START);
        chk("start_score", score, 0);

        // First jump: left, 3 -> 2, score 1
        do_jump(1'b0, 1'b0, 1'b0, 1);
        chk("first_score", score, 1);
        chk("first_column", column, 2);

        // Queued jump in the same and opposite direction
        do_jump(1'b1, 1'b1, 1'b1, 2);
        do_jump(1'b0, 1'b1, 1'b1, 1);

        // Randomized play
        for (int i = 0; i < 24; i++) begin
            do_jump(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), 3);
        end

        // Left boundary
        while (m_col > 0) do_jump(1'b0, 1'b0, 1'b0, 0);
        do_jump(1'b0, 1'b0, 1'b0, 0);
        chk("left_edge_col", column, 0);
        chk("left_edge_run", module_en, 1);
        chk("left_edge_busy", busy, 0);

        // Right boundary
        while (m_col < COL_MAX) do_jump(1'b1, 1'b0, 1'b0, 0);
        do_jump(1'b1, 1'b0, 1'b0, 0);
        chk("right_edge_col", column, COL_MAX);
        chk("right_edge_busy", busy, 0);

        // Simultaneous edges are dropped
        press_raw(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("both_col", column, m_col);
        chk("both_busy", busy, 0);

        // jump_fail during SHIFT
        start_jump(1'b0, ok);
        run_ticks(2, 1, 1'b1, 1'b0, 1'b0, last);
        jump_fail = 1'b1;
        @(negedge clk);
        jump_fail = 1'b0;
        chk("fail_game_over", game_over, 1);
        chk("fail_module_en", module_en, 0);
        chk("fail_busy", busy, 0);
        press_raw(1'b0, 1'b1);
        run_ticks(SHIFT_MS, 0, 1'b0, 1'b0, 1'b0, last);
        repeat (2) @(negedge clk);
        chk("fail_score_frozen", score, m_score);
        chk("fail_col_frozen", column, m_col);
        chk("fail_still_over", game_over, 1);
        game_active = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_fail", game_over, 0);
        chk("idle_after_fail_en", module_en, 0);

        // New game, then reset mid-SHIFT
        game_active = 1'b1;
        repeat (2) @(negedge clk);
        m_col   = COL_START;
        m_score = 0;
        chk("restart_col", column, COL_START);
        chk("restart_score", score, 0);
        do_jump(1'b1, 1'b0, 1'b0, 1);
        start_jump(1'b0, ok);
        run_ticks(1, 0, 1'b1, 1'b0, 1'b0, last);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_column", column, COL_START);
        chk("midrst_score", score, 0);
        chk("midrst_layer", layer_select, 0);
        game_active = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        // LFSR sequence from seed, then score saturation
        game_active = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 1030; i++) begin
            bit d;
            d = 1'($urandom_range(1, 0));
            if (!in_range(d, m_col)) d = !d;
            do_jump(d, 1'b0, 1'b0, 0);
        end
        chk("score_saturated", score, 1023);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
